// File: rtl/blink_pkg.sv
// Shared types for the LED blink scheduler: config modes, per-channel states
// and the state-to-LED mapping used by every channel.
package blink_pkg;

   localparam int MODE_W = 2;
   localparam int CH_W   = 4;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } blink_mode_e;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_ON     = 3'd1,
      ST_BLK_HI = 3'd2,
      ST_BLK_LO = 3'd3,
      ST_BST_HI = 3'd4,
      ST_BST_LO = 3'd5
   } chan_state_e;

   // LED level implied by a channel state
   function automatic logic state_led(input chan_state_e st);
      logic lvl;
      case (st)
         ST_ON:     lvl = 1'b1;
         ST_BLK_HI: lvl = 1'b1;
         ST_BST_HI: lvl = 1'b1;
         default:   lvl = 1'b0;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: OFF / ON / BLINK / BURST state machine advanced by the
// shared prescaler tick, with registered LED and burst-done outputs.
module blink_chan
   import blink_pkg::*;
#(
   parameter int NBITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_i,
   input  logic             wr_i,
   input  blink_mode_e      mode_i,
   input  logic [NBITS-1:0] count_i,
   output logic             led_o,
   output logic             done_o
);

   chan_state_e      state_q;
   logic [NBITS-1:0] rem_q;
   logic             led_q;
   logic             done_q;

   // Channel FSM; a write always wins because writes never land on a tick edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OFF;
         rem_q   <= {NBITS{1'b0}};
         led_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (wr_i) begin
            case (mode_i)
               MODE_OFF: begin
                  state_q <= ST_OFF;
                  led_q   <= state_led(ST_OFF);
               end
               MODE_ON: begin
                  state_q <= ST_ON;
                  led_q   <= state_led(ST_ON);
               end
               MODE_BLINK: begin
                  state_q <= ST_BLK_HI;
                  led_q   <= state_led(ST_BLK_HI);
               end
               MODE_BURST: begin
                  if (count_i == {NBITS{1'b0}}) begin
                     state_q <= ST_OFF;
                     led_q   <= state_led(ST_OFF);
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_BST_HI;
                     rem_q   <= count_i - NBITS'(1);
                     led_q   <= state_led(ST_BST_HI);
                  end
               end
               default: begin
                  state_q <= ST_OFF;
                  led_q   <= 1'b0;
               end
            endcase
         end else if (tick_i) begin
            case (state_q)
               ST_BLK_HI: begin
                  state_q <= ST_BLK_LO;
                  led_q   <= state_led(ST_BLK_LO);
               end
               ST_BLK_LO: begin
                  state_q <= ST_BLK_HI;
                  led_q   <= state_led(ST_BLK_HI);
               end
               ST_BST_HI: begin
                  state_q <= ST_BST_LO;
                  led_q   <= state_led(ST_BST_LO);
               end
               ST_BST_LO: begin
                  if (rem_q != {NBITS{1'b0}}) begin
                     state_q <= ST_BST_HI;
                     rem_q   <= rem_q - NBITS'(1);
                     led_q   <= state_led(ST_BST_HI);
                  end else begin
                     state_q <= ST_OFF;
                     led_q   <= state_led(ST_OFF);
                     done_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= state_q;
                  led_q   <= led_q;
               end
            endcase
         end else begin
            state_q <= state_q;
            rem_q   <= rem_q;
            led_q   <= led_q;
         end
      end
   end

   assign led_o  = led_q;
   assign done_o = done_q;

endmodule

// File: rtl/blink_sched.sv
// Multi-channel LED blink scheduler: one free-running prescaler provides the
// tick for all channels; a valid/ready port reconfigures one channel at a time.
module blink_sched
   import blink_pkg::*;
#(
   parameter int CBITS = 12,
   parameter int NCH   = 4,
   parameter int NBITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [MODE_W-1:0] cfg_mode_i,
   input  logic [NBITS-1:0]  cfg_count_i,
   output logic [NCH-1:0]    led_o,
   output logic [NCH-1:0]    done_o,
   output logic              tick_o
);

   logic [CBITS-1:0] cnt_q;
   logic             tick_q;
   logic             tick_s;
   logic             xfer_s;
   logic [NCH-1:0]   wr_s;
   blink_mode_e      mode_s;

   assign tick_s      = (cnt_q == {CBITS{1'b0}});
   // Holding off configs on the tick edge removes any config/tick priority question
   assign cfg_ready_o = ~tick_s;
   assign xfer_s      = cfg_valid_i & cfg_ready_o;
   assign mode_s      = blink_mode_e'(cfg_mode_i);
   assign tick_o      = tick_q;

   // Shared prescaler and registered tick pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= {CBITS{1'b0}};
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_q + CBITS'(1);
         tick_q <= tick_s;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign wr_s[i] = xfer_s & (cfg_ch_i == CH_W'(i));

      blink_chan #(
         .NBITS (NBITS)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .tick_i  (tick_s),
         .wr_i    (wr_s[i]),
         .mode_i  (mode_s),
         .count_i (cfg_count_i),
         .led_o   (led_o[i]),
         .done_o  (done_o[i])
      );
   end

endmodule

// File: tb/tb_blink_sched.sv
// Scoreboard bench for blink_sched with an 8-cycle prescaler: expected LED/done
// per post-reset clock edge are queued up front and popped by a monitor.
module tb_blink_sched;

   localparam int CBITS = 3;
   localparam int NCH   = 4;
   localparam int NBITS = 4;
   localparam int PER   = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [3:0]       cfg_ch = 4'd0;
   logic [1:0]       cfg_mode = 2'd0;
   logic [NBITS-1:0] cfg_count = 4'd0;
   logic [NCH-1:0]   led;
   logic [NCH-1:0]   done;
   logic             tick;

   int checks = 0;
   int errors = 0;
   int e;

   typedef struct {
      int         cyc;
      logic [3:0] led;
      logic [3:0] done;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;

   blink_sched #(
      .CBITS (CBITS),
      .NCH   (NCH),
      .NBITS (NBITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_ch_i    (cfg_ch),
      .cfg_mode_i  (cfg_mode),
      .cfg_count_i (cfg_count),
      .led_o       (led),
      .done_o      (done),
      .tick_o      (tick)
   );

   always #5 clk = ~clk;

   // edge index since reset release; sample e is taken on the negedge after edge e
   always @(posedge clk or posedge rst) begin
      if (rst) e <= 0;
      else     e <= e + 1;
   end

   task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, act, expv);
      end
   endtask

   task automatic push_seg(input int first, input int last, input logic [3:0] l, input logic [3:0] d);
      exp_t x;
      for (int c = first; c <= last; c++) begin
         x.cyc  = c;
         x.led  = l;
         x.done = d;
         exp_q.push_back(x);
      end
   endtask

   task automatic wait_sample(input int n);
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (e != n && guard < 1000);
      if (e != n) begin
         checks++;
         errors++;
         $display("FAIL wait_sample got=%0d exp=%0d", e, n);
      end
   endtask

   task automatic do_cfg(input logic [3:0] ch, input logic [1:0] mode, input logic [3:0] cnt);
      int guard = 0;
      cfg_ch    = ch;
      cfg_mode  = mode;
      cfg_count = cnt;
      cfg_valid = 1'b1;
      while (!cfg_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!cfg_ready) begin
         checks++;
         errors++;
         $display("FAIL cfg_timeout got=%0d exp=%0d", cfg_ready, 1);
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // monitor: compare DUT outputs against the queued expectation for this edge
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && e > 0) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < e) begin
               cur = exp_q.pop_front();
               check("stale_entry", e, cur.cyc, e);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == e) begin
               cur = exp_q.pop_front();
               check("led",   e, led,       cur.led);
               check("done",  e, done,      cur.done);
               check("tick",  e, tick,      (e % PER) == 1);
               check("ready", e, cfg_ready, (e % PER) != 0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      push_seg(1,   18,  4'b0000, 4'b0000);
      push_seg(19,  22,  4'b0001, 4'b0000);
      push_seg(23,  26,  4'b0000, 4'b0000);
      push_seg(27,  32,  4'b0010, 4'b0000);
      push_seg(33,  40,  4'b0000, 4'b0000);
      push_seg(41,  48,  4'b0010, 4'b0000);
      push_seg(49,  56,  4'b0000, 4'b0000);
      push_seg(57,  60,  4'b0010, 4'b0000);
      push_seg(61,  62,  4'b0000, 4'b0000);
      push_seg(63,  64,  4'b0100, 4'b0000);
      push_seg(65,  72,  4'b0000, 4'b0000);
      push_seg(73,  80,  4'b0100, 4'b0000);
      push_seg(81,  88,  4'b0000, 4'b0000);
      push_seg(89,  96,  4'b0100, 4'b0000);
      push_seg(97,  104, 4'b0000, 4'b0000);
      push_seg(105, 105, 4'b0000, 4'b0100);
      push_seg(106, 106, 4'b0000, 4'b0000);
      push_seg(107, 107, 4'b0000, 4'b0100);
      push_seg(108, 113, 4'b0000, 4'b0000);
      push_seg(114, 118, 4'b0001, 4'b0000);
      push_seg(119, 122, 4'b0000, 4'b0000);
      push_seg(123, 128, 4'b1000, 4'b0000);
      push_seg(129, 130, 4'b0000, 4'b0000);
      push_seg(131, 136, 4'b1000, 4'b0000);
      push_seg(137, 144, 4'b0000, 4'b0000);
      push_seg(145, 148, 4'b1000, 4'b0000);

      #12;
      check("rst_led",   0, led,       4'b0000);
      check("rst_done",  0, done,      4'b0000);
      check("rst_tick",  0, tick,      1'b0);
      check("rst_ready", 0, cfg_ready, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      wait_sample(18);  do_cfg(4'd0, 2'd1, 4'd0);
      wait_sample(22);  do_cfg(4'd0, 2'd0, 4'd0);
      wait_sample(26);  do_cfg(4'd1, 2'd2, 4'd0);
      wait_sample(60);  do_cfg(4'd1, 2'd0, 4'd0);
      wait_sample(62);  do_cfg(4'd2, 2'd3, 4'd3);
      wait_sample(106); do_cfg(4'd2, 2'd3, 4'd0);
      wait_sample(112); do_cfg(4'd0, 2'd1, 4'd0);
      wait_sample(116); do_cfg(4'd7, 2'd1, 4'd0);
      wait_sample(118); do_cfg(4'd0, 2'd0, 4'd0);
      wait_sample(122); do_cfg(4'd3, 2'd3, 4'd5);
      wait_sample(130); do_cfg(4'd3, 2'd2, 4'd0);

      wait_sample(148);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_led",  148, led,  4'b0000);
      check("async_rst_done", 148, done, 4'b0000);
      check("async_rst_tick", 148, tick, 1'b0);
      push_seg(1, 12, 4'b0000, 4'b0000);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      wait_sample(12);
      @(negedge clk);
      check("queue_drained", e, exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
